// File: rtl/tcalc_pkg.sv
// tcalc_pkg: shared constants and helpers for the sequential exercise-time calculator.
// Contents: FSM state encodings, MET burn-factor table, gender energy factors,
// and width helpers used to size the numerator (N) and divisor (R) datapaths.
package tcalc_pkg;

    // FSM state encodings
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Gender energy factors and the largest table entries used for sizing
    localparam int unsigned GF_MALE    = 16;
    localparam int unsigned GF_FEMALE  = 18;
    localparam int unsigned GF_MAX     = 18;
    localparam int unsigned MET_MAX    = 11;
    localparam int unsigned CAL_MULT_MAX = 4;

    // MET burn factor lookup {3, 5, 8, 11}
    function automatic int unsigned met_factor(input logic [1:0] m);
        int unsigned f;
        f = 11;
        case (m)
            2'd0:    f = 3;
            2'd1:    f = 5;
            2'd2:    f = 8;
            default: f = 11;
        endcase
        return f;
    endfunction

    // Energy scale per gender (1 = male)
    function automatic int unsigned gender_factor(input logic g);
        return g ? GF_MALE : GF_FEMALE;
    endfunction

    // Bits needed to hold the value v
    function automatic int unsigned bits_for(input int unsigned v);
        return unsigned'($clog2(v + 1));
    endfunction

    // Numerator width: worst case (cal+1)=4, female factor
    function automatic int unsigned n_bits(input int unsigned cal_step);
        return bits_for(CAL_MULT_MAX * cal_step * GF_MAX);
    endfunction

    // Divisor width: worst case MET 11 times the largest offset weight
    function automatic int unsigned r_bits(input int unsigned w_bits, input int unsigned w_base);
        return bits_for(MET_MAX * ((32'd1 << w_bits) - 32'd1 + w_base));
    endfunction

endpackage

// File: rtl/tcalc_div.sv
// tcalc_div: bit-serial restoring divider, one quotient bit per cycle, MSB first.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        load num/den and begin an N_BITS-step division
//   num, den     numerator and (non-zero) divisor, sampled on start
//   quot_c       quotient including the bit resolved this cycle (final on done_c)
//   done_c       high during the last division step
module tcalc_div #(
    parameter int unsigned N_BITS = 13,
    parameter int unsigned R_BITS = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_BITS-1:0] num,
    input  logic [R_BITS-1:0] den,
    output logic [N_BITS-1:0] quot_c,
    output logic              done_c
);

    localparam int unsigned CNT_BITS = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    logic [N_BITS-1:0]   q;
    logic [R_BITS-1:0]   rem;
    logic [R_BITS-1:0]   den_q;
    logic [CNT_BITS-1:0] cnt;
    logic                busy;

    logic [R_BITS:0]     trial_c;
    logic [R_BITS:0]     diff_c;
    logic                qbit_c;
    logic [R_BITS-1:0]   rem_next_c;

    // One restoring step: shift in the next numerator bit, subtract if it fits.
    // rem < den, so trial < 2*den and the kept remainder always fits R_BITS.
    always_comb begin
        trial_c    = {rem, q[N_BITS-1]};
        diff_c     = trial_c - {1'b0, den_q};
        qbit_c     = (trial_c >= {1'b0, den_q});
        rem_next_c = qbit_c ? diff_c[R_BITS-1:0] : trial_c[R_BITS-1:0];
        quot_c     = {q[N_BITS-2:0], qbit_c};
        done_c     = busy && (cnt == '0);
    end

    // q shifts numerator bits out the top and quotient bits in the bottom
    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            rem   <= '0;
            den_q <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            q     <= num;
            rem   <= '0;
            den_q <= den;
            cnt   <= CNT_BITS'(N_BITS - 1);
            busy  <= 1'b1;
        end else if (busy) begin
            q   <= quot_c;
            rem <= rem_next_c;
            cnt <= cnt - CNT_BITS'(1);
            if (cnt == '0) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tcalc_seq.sv
// tcalc_seq: sequential exercise-time calculator.
// Captures one profile over valid/ready, forms N = (cal+1)*CAL_STEP*GF and
// R = MET[met]*(w+W_BASE), then computes T = floor(N/R) with tcalc_div.
// Result is held in DONE until out_ready.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   profile handshake (in_ready only in IDLE)
//   w, cal, met, g        weight class, calorie index, MET index, gender (1 = male)
//   out_valid / out_ready result handshake
//   T                     exercise time in minutes
//   t_sat                 result clipped to all-ones
// Build option: define TCALC_SEQ_SAT_EN to saturate quotients >= 2^T_BITS;
// otherwise T wraps to the low T_BITS bits and t_sat stays 0.
module tcalc_seq
    import tcalc_pkg::*;
#(
    parameter int unsigned W_BITS   = 3,
    parameter int unsigned T_BITS   = 9,
    parameter int unsigned CAL_STEP = 100,
    parameter int unsigned W_BASE   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_BITS-1:0] w,
    input  logic [1:0]        cal,
    input  logic [1:0]        met,
    input  logic              g,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [T_BITS-1:0] T,
    output logic              t_sat
);

    localparam int unsigned N_BITS = n_bits(CAL_STEP);
    localparam int unsigned R_BITS = r_bits(W_BITS, W_BASE);

    logic [1:0]        state;
    logic [1:0]        state_next;

    logic [W_BITS-1:0] w_q;
    logic [1:0]        cal_q;
    logic [1:0]        met_q;
    logic              g_q;

    logic [N_BITS-1:0] n_c;
    logic [R_BITS-1:0] r_c;
    logic              div_start_c;
    logic [N_BITS-1:0] quot_c;
    logic              div_done_c;

    logic [T_BITS-1:0] t_next_c;
    logic              sat_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (in_valid)   state_next = S_PREP;
            S_PREP:                 state_next = S_DIV;
            S_DIV:  if (div_done_c) state_next = S_DONE;
            S_DONE: if (out_ready)  state_next = S_IDLE;
            default:                state_next = S_IDLE;
        endcase
    end

    // Operand prep from the captured profile; constant multiplies only
    always_comb begin
        n_c         = N_BITS'((32'(cal_q) + 32'd1) * CAL_STEP * gender_factor(g_q));
        r_c         = R_BITS'(met_factor(met_q) * (32'(w_q) + W_BASE));
        div_start_c = (state == S_PREP);
    end

    tcalc_div #(
        .N_BITS (N_BITS),
        .R_BITS (R_BITS)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .start  (div_start_c),
        .num    (n_c),
        .den    (r_c),
        .quot_c (quot_c),
        .done_c (div_done_c)
    );

`ifdef TCALC_SEQ_SAT_EN
    localparam int unsigned X_BITS = ((N_BITS > T_BITS) ? N_BITS : T_BITS) + 1;
    logic [X_BITS-1:0] quot_x_c;

    // Clip quotients that do not fit T_BITS to all-ones
    always_comb begin
        quot_x_c = X_BITS'(quot_c);
        sat_c    = (quot_x_c > X_BITS'({T_BITS{1'b1}}));
        t_next_c = sat_c ? {T_BITS{1'b1}} : T_BITS'(quot_c);
    end
`else
    // Keep the low T_BITS bits of the quotient
    always_comb begin
        sat_c    = 1'b0;
        t_next_c = T_BITS'(quot_c);
    end
`endif

    // Handshake flags, profile capture and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            T         <= '0;
            t_sat     <= 1'b0;
            w_q       <= '0;
            cal_q     <= '0;
            met_q     <= '0;
            g_q       <= 1'b0;
        end else begin
            in_ready  <= (state_next == S_IDLE);
            out_valid <= (state_next == S_DONE);
            if ((state == S_IDLE) && in_valid) begin
                w_q   <= w;
                cal_q <= cal;
                met_q <= met;
                g_q   <= g;
            end
            if ((state == S_DIV) && div_done_c) begin
                T     <= t_next_c;
                t_sat <= sat_c;
            end
        end
    end

endmodule

// File: tb/tb_tcalc_seq.sv
// tb_tcalc_seq: directed self-checking bench for tcalc_seq with a result scoreboard.
// Honors TCALC_SEQ_SAT_EN for the expected clip/wrap behaviour.
module tb_tcalc_seq;

    typedef struct {
        logic [8:0] t;
        logic       sat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] w;
    logic [1:0] cal;
    logic [1:0] met;
    logic       g;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] T;
    logic       t_sat;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    tcalc_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .w         (w),
        .cal       (cal),
        .met       (met),
        .g         (g),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .T         (T),
        .t_sat     (t_sat)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: T = floor(N/R) from the profile
    function automatic exp_t model(input logic [2:0] wv, input logic [1:0] cv,
                                   input logic [1:0] mv, input logic gv);
        exp_t e;
        int unsigned n, r, q, mt;
        case (mv)
            2'd0:    mt = 3;
            2'd1:    mt = 5;
            2'd2:    mt = 8;
            default: mt = 11;
        endcase
        n = (32'(cv) + 1) * 100 * (gv ? 16 : 18);
        r = mt * (32'(wv) + 4);
        q = n / r;
`ifdef TCALC_SEQ_SAT_EN
        if (q > 511) begin
            e.t = 9'd511; e.sat = 1'b1;
        end else begin
            e.t = 9'(q); e.sat = 1'b0;
        end
`else
        e.t = 9'(q % 512); e.sat = 1'b0;
`endif
        return e;
    endfunction

    // Present a profile until accepted, push its expectation, return one cycle later
    task automatic send(input logic [2:0] wv, input logic [1:0] cv,
                        input logic [1:0] mv, input logic gv);
        int n;
        n = 0;
        w = wv; cal = cv; met = mv; g = gv; in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk); n++;
        end
        check("accept_wait", 32'(in_ready), 1);
        if (in_ready) sb.push_back(model(wv, cv, mv, gv));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk); n++;
        end
        check("out_timeout", 32'(out_valid), 1);
    endtask

    // Compare the presented result with the scoreboard head and consume it
    task automatic take(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_T"}, 32'(T), 32'(e.t));
            check({tag, "_sat"}, 32'(t_sat), 32'(e.sat));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, 32'(out_valid), 0);
        check({tag, "_ir_rise"}, 32'(in_ready), 1);
    endtask

    initial begin
        int   n;
        int   hits;
        int   accepts;
        int   results;
        int   last_cyc;
        int   cyc;
        logic acc_now;
        exp_t e;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        w = '0; cal = '0; met = '0; g = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_T", 32'(T), 0);
        check("rst_t_sat", 32'(t_sat), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic result and latency from the accept cycle
        send(3'd0, 2'd0, 2'd0, 1'b1);
        wait_out(n);
        check("t1_latency", 32'(n + 1), 15);
        check("t1_T_const", 32'(T), 133);
        take("t1");

        // Hold the result with out_ready low
        send(3'd7, 2'd3, 2'd3, 1'b0);
        wait_out(n);
        for (int i = 0; i < 20; i++) begin
            check("t2_hold_ov", 32'(out_valid), 1);
            check("t2_hold_T", 32'(T), 59);
            check("t2_hold_ir", 32'(in_ready), 0);
            @(negedge clk);
        end
        take("t2");

        // Quotient beyond T width
        send(3'd0, 2'd3, 2'd0, 1'b0);
        wait_out(n);
`ifdef TCALC_SEQ_SAT_EN
        check("t3_T_const", 32'(T), 511);
        check("t3_sat_const", 32'(t_sat), 1);
`else
        check("t3_T_const", 32'(T), 88);
        check("t3_sat_const", 32'(t_sat), 0);
`endif
        take("t3");

        // Input changes, in_valid and out_ready during DIV are ignored
        send(3'd1, 2'd2, 2'd1, 1'b1);
        repeat (3) @(negedge clk);
        w = 3'd6; cal = 2'd0; met = 2'd3; g = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        check("t4_ir_busy", 32'(in_ready), 0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        wait_out(n);
        check("t4_T_const", 32'(T), 192);
        take("t4");

        // Reset mid-division, with in_valid in the reset cycle
        send(3'd5, 2'd2, 2'd1, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; w = 3'd2; cal = 2'd1; met = 2'd1; g = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        check("t5_ir", 32'(in_ready), 1);
        check("t5_ov", 32'(out_valid), 0);
        check("t5_T", 32'(T), 0);
        check("t5_sat", 32'(t_sat), 0);
        if (sb.size() != 0) e = sb.pop_back();
        @(negedge clk);
        check("t5_no_capture", 32'(in_ready), 1);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) hits++;
            @(negedge clk);
        end
        check("t5_discarded", 32'(hits), 0);
        send(3'd3, 2'd1, 2'd2, 1'b1);
        wait_out(n);
        check("t5_T_const", 32'(T), 57);
        take("t5");

        // Back-to-back with both handshakes held high
        accepts = 0; results = 0; last_cyc = -1; cyc = 0;
        w = 3'($urandom_range(0, 7)); cal = 2'($urandom_range(0, 3));
        met = 2'($urandom_range(0, 3)); g = 1'($urandom_range(0, 1));
        in_valid = 1'b1; out_ready = 1'b1;
        while (results < 8 && cyc < 400) begin
            acc_now = 1'b0;
            if (out_valid) begin
                check("b2b_sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("b2b_T", 32'(T), 32'(e.t));
                    check("b2b_sat", 32'(t_sat), 32'(e.sat));
                end
                if (last_cyc >= 0) check("b2b_spacing", 32'(cyc - last_cyc), 16);
                last_cyc = cyc;
                results++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(w, cal, met, g));
                accepts++;
                acc_now = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (acc_now) begin
                w = 3'($urandom_range(0, 7)); cal = 2'($urandom_range(0, 3));
                met = 2'($urandom_range(0, 3)); g = 1'($urandom_range(0, 1));
                if (accepts == 8) in_valid = 1'b0;
            end
        end
        check("b2b_count", 32'(results), 8);
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
